// File: rtl/motor_drive.sv
// L298N dual H-bridge driver: command glitch filter, dead time on every
// direction change, duty ramp and free-running PWM enables.
module motor_drive #(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_MAX    = 200,
  parameter int RAMP_DIV    = 1000,
  parameter int DEAD_CYCLES = 50000,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic                stop,
  input  logic                backward,
  input  logic                turn_left,
  input  logic                turn_right,
  output logic                in1,
  output logic                in2,
  output logic                in3,
  output logic                in4,
  output logic                ena,
  output logic                enb,
  output logic [1:0]          motor_state,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(DUTY_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    RAMP = 2'd2,
    RUN  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    R_FWD   = 3'd0,
    R_BWD   = 3'd1,
    R_LEFT  = 3'd2,
    R_RIGHT = 3'd3,
    R_STOP  = 3'd4
  } req_t;

  state_t              state;
  req_t                req;
  req_t                prev_req;
  req_t                dir;
  logic [HW-1:0]       hold_cnt;
  logic [HW-1:0]       hold_nxt;
  logic [DW-1:0]       dead_cnt;
  logic [RW-1:0]       ramp_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [3:0]          pins;
  logic                accept;
  logic                go_dead;
  logic                pwm_on;

  function automatic logic [3:0] pin_map(req_t d);
    logic [3:0] p;
    p = 4'b0000;
    case (d)
      R_FWD:   p = 4'b1010;
      R_BWD:   p = 4'b0101;
      R_LEFT:  p = 4'b0110;
      R_RIGHT: p = 4'b1001;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  always_comb begin
    req = R_FWD;
    if (stop)            req = R_STOP;
    else if (backward)   req = R_BWD;
    else if (turn_left)  req = R_LEFT;
    else if (turn_right) req = R_RIGHT;

    hold_nxt = '0;
    if (req == prev_req)
      hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HW'(1);

    // Level acceptance: a held request keeps re-accepting, which is harmless
    // because a command equal to dir has no effect.
    accept  = (req != R_STOP) && (hold_nxt == HOLD_LAST);
    go_dead = accept && ((state == IDLE) || (req != dir));
    pwm_on  = pwm_cnt < duty;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dir      <= R_FWD;
      prev_req <= R_FWD;
      hold_cnt <= '0;
      dead_cnt <= '0;
      ramp_cnt <= '0;
      pwm_cnt  <= '0;
      duty     <= '0;
      pins     <= '0;
      ena      <= 1'b0;
      enb      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      prev_req <= req;
      // Drop the bridge at once on stop or reversal, not one PWM sample late.
      ena      <= pwm_on && !(stop || go_dead);
      enb      <= pwm_on && !(stop || go_dead);
      if (stop) begin
        state    <= IDLE;
        duty     <= '0;
        pins     <= '0;
        busy     <= 1'b0;
        hold_cnt <= '0;
        dead_cnt <= '0;
        ramp_cnt <= '0;
      end else begin
        hold_cnt <= hold_nxt;
        if (go_dead) begin
          state    <= DEAD;
          dir      <= req;
          pins     <= pin_map(req);
          duty     <= '0;
          busy     <= 1'b1;
          dead_cnt <= DEAD_LOAD;
          ramp_cnt <= '0;
        end else begin
          case (state)
            DEAD: begin
              if (dead_cnt == '0) begin
                state <= (DUTY_MAX == 0) ? RUN : RAMP;
                busy  <= (DUTY_MAX != 0);
              end else begin
                dead_cnt <= dead_cnt - DW'(1);
              end
            end
            RAMP: begin
              if (ramp_cnt == RAMP_LAST) begin
                ramp_cnt <= '0;
                duty     <= duty + PWM_BITS'(1);
                if (duty + PWM_BITS'(1) == DMAX) begin
                  state <= RUN;
                  busy  <= 1'b0;
                end
              end else begin
                ramp_cnt <= ramp_cnt + RW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign {in1, in2, in3, in4} = pins;
  assign motor_state = state;

endmodule

// File: tb/tb_motor_drive.sv
// Scoreboarded directed bench for motor_drive: expectations are queued by
// target cycle and a negedge monitor pops and compares them.
module tb_motor_drive;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       stop = 1'b0;
  logic       backward = 1'b0;
  logic       turn_left = 1'b0;
  logic       turn_right = 1'b0;
  logic       in1, in2, in3, in4, ena, enb, busy;
  logic [1:0] motor_state;
  logic [3:0] duty;

  motor_drive #(
    .PWM_BITS(4), .DUTY_MAX(6), .RAMP_DIV(2),
    .DEAD_CYCLES(8), .HOLD_CYCLES(4)
  ) dut (
    .clk_50m(clk_50m), .rst(rst),
    .stop(stop), .backward(backward),
    .turn_left(turn_left), .turn_right(turn_right),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .ena(ena), .enb(enb),
    .motor_state(motor_state), .duty(duty), .busy(busy)
  );

  always #5 clk_50m = ~clk_50m;

  typedef struct {
    int         cyc;
    string      name;
    bit         full;
    logic [1:0] st;
    logic [3:0] pins;
    logic [3:0] d;
    logic       b;
    bit         chk_en;
    logic       en;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   base = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic expf(int k, string n, logic [1:0] st, logic [3:0] p,
                      logic [3:0] d, logic b);
    exp_t e;
    e = '{cyc: base + k, name: n, full: 1'b1, st: st, pins: p, d: d,
          b: b, chk_en: 1'b0, en: 1'b0};
    q.push_back(e);
  endtask

  task automatic expe(int k, string n, logic en);
    exp_t e;
    e = '{cyc: base + k, name: n, full: 1'b0, st: 2'd0, pins: 4'd0,
          d: 4'd0, b: 1'b0, chk_en: 1'b1, en: en};
    q.push_back(e);
  endtask

  always @(negedge clk_50m) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [3:0] p;
      bit ok;
      e = q.pop_front();
      p = {in1, in2, in3, in4};
      ok = (e.cyc == cyc);
      if (e.full)
        ok = ok && motor_state == e.st && p == e.pins &&
             duty == e.d && busy == e.b;
      if (e.chk_en)
        ok = ok && ena == e.en && enb == e.en;
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (want %0d): got st=%0d in=%b duty=%0d busy=%b ena=%b enb=%b, want st=%0d in=%b duty=%0d busy=%b ena=%b",
                 e.name, cyc, e.cyc, motor_state, p, duty, busy, ena, enb,
                 e.st, e.pins, e.d, e.b, e.en);
      end
    end
  end

  task automatic go(int k);
    while (cyc < base + k) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  initial begin
    exp_t r;
    r = '{cyc: 1, name: "reset", full: 1'b1, st: 2'd0, pins: 4'd0,
          d: 4'd0, b: 1'b0, chk_en: 1'b1, en: 1'b0};
    q.push_back(r);
    #22;
    rst = 1'b0;
    base = cyc;

    expf(2, "fwd_idle", 0, 4'b0000, 0, 0);
    expe(2, "fwd_idle_en", 0);
    expf(3, "fwd_dead", 1, 4'b1010, 0, 1);
    expe(3, "fwd_dead_en", 0);
    expf(10, "fwd_dead_end", 1, 4'b1010, 0, 1);
    expf(11, "fwd_ramp0", 2, 4'b1010, 0, 1);
    expe(11, "fwd_ramp0_en", 0);
    expf(13, "fwd_ramp1", 2, 4'b1010, 1, 1);
    expf(17, "fwd_ramp3", 2, 4'b1010, 3, 1);
    expf(22, "fwd_ramp5", 2, 4'b1010, 5, 1);
    expf(23, "fwd_run", 3, 4'b1010, 6, 0);
    for (int k = 24; k <= 39; k++)
      expe(k, "run_pwm", (k >= 33 && k <= 38));
    expf(44, "glitch_run", 3, 4'b1010, 6, 0);
    expf(48, "glitch_settle", 3, 4'b1010, 6, 0);
    expf(53, "rev_dead", 1, 4'b0101, 0, 1);
    expe(53, "rev_dead_en", 0);
    for (int k = 54; k <= 60; k++)
      expe(k, "rev_dead_en", 0);
    expf(60, "rev_dead_end", 1, 4'b0101, 0, 1);
    expf(61, "rev_ramp0", 2, 4'b0101, 0, 1);
    expe(61, "rev_ramp0_en", 0);
    expf(67, "rev_ramp3", 2, 4'b0101, 3, 1);
    expf(68, "stop_idle", 0, 4'b0000, 0, 0);
    expe(68, "stop_en", 0);
    expf(71, "stop_hold", 0, 4'b0000, 0, 0);
    expf(72, "prio_dead", 1, 4'b0101, 0, 1);
    expf(96, "prio_run", 3, 4'b0101, 6, 0);
    expf(97, "prio_stop", 0, 4'b0000, 0, 0);
    expe(97, "prio_stop_en", 0);
    expf(100, "prio_stop_held", 0, 4'b0000, 0, 0);
    expf(104, "prio_redead", 1, 4'b0101, 0, 1);
    expf(129, "pre_rst_run", 3, 4'b0101, 6, 0);
    expe(129, "pre_rst_en", 1);

    go(40);  turn_left = 1'b1;
    go(43);  turn_left = 1'b0;
    go(49);  backward = 1'b1;
    go(67);  stop = 1'b1;
    go(68);  stop = 1'b0; turn_left = 1'b1; turn_right = 1'b1;
    go(96);  stop = 1'b1;
    go(100); stop = 1'b0;
    go(130);
    rst = 1'b1;
    backward = 1'b0; turn_left = 1'b0; turn_right = 1'b0;
    expf(130, "async_rst", 0, 4'b0000, 0, 0);
    expe(130, "async_rst_en", 0);
    go(132);
    rst = 1'b0;
    base = cyc;
    expf(2, "restart_idle", 0, 4'b0000, 0, 0);
    expf(3, "restart_dead", 1, 4'b1010, 0, 1);
    expe(3, "restart_en", 0);
    go(6);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk_50m);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
